// File: rtl/vector_req_arbiter_if.sv
// Handshake bundle between the vector request arbiter, its consumers and the shared vector buffer.
// Latency: none (wires only).
// Backpressure: none here; consumers hold cons_req until their cons_ack.
//
// Signals:
//   cons_req    consumer -> arbiter  per-consumer level request
//   cons_ack    arbiter -> consumer  one-hot completion pulse
//   cons_hit    arbiter -> consumer  1 = vector delivered, 0 = buffer miss
//   cons_vector arbiter -> consumer  returned vector (0 on miss / no ack)
//   buf_req     arbiter -> buffer    single-cycle read strobe
//   buf_vector  buffer  -> arbiter   data, one cycle after buf_req
//   buf_valid   buffer  -> arbiter   data qualifier, same timing as buf_vector
//   hit_count   arbiter -> observer  saturating hit completions
//   miss_count  arbiter -> observer  saturating miss completions
//
// slave is the arbiter's view; master is the surrounding environment's view.
interface vector_req_arbiter_if #(
    parameter int NB_REQ = 4
);
    logic [NB_REQ-1:0] cons_req;
    logic [NB_REQ-1:0] cons_ack;
    logic              cons_hit;
    logic [7:0]        cons_vector;
    logic              buf_req;
    logic [7:0]        buf_vector;
    logic              buf_valid;
    logic [7:0]        hit_count;
    logic [7:0]        miss_count;

    modport slave (
        input  cons_req, buf_vector, buf_valid,
        output cons_ack, cons_hit, cons_vector, buf_req, hit_count, miss_count
    );

    modport master (
        output cons_req, buf_vector, buf_valid,
        input  cons_ack, cons_hit, cons_vector, buf_req, hit_count, miss_count
    );
endinterface

// File: rtl/vector_req_arbiter.sv
// Round-robin arbiter granting consumers one read of a shared vector buffer at a time.
// Latency: request seen in IDLE at cycle N -> buf_req at N+1 -> cons_ack at N+3.
// Backpressure: requests wait while a transaction is in flight or during post-miss backoff.
//
// Ports:
//   clk  single clock, all state on posedge
//   rst  asynchronous active-high reset
//   bus  vector_req_arbiter_if.slave (consumer request/ack, buffer request/response, counters)
module vector_req_arbiter #(
    parameter int NB_REQ  = 4,
    parameter int BACKOFF = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    vector_req_arbiter_if.slave  bus
);
    localparam int IDX_W = $clog2(NB_REQ);
    // Last value of the backoff counter before returning to IDLE.
    localparam logic [3:0] BO_LAST = (BACKOFF > 0) ? 4'(BACKOFF - 1) : 4'd0;
    localparam logic [NB_REQ-1:0] ONE_HOT0 = {{(NB_REQ-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP,
        HOLD
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] grant;
    logic [IDX_W-1:0] pick;
    logic [3:0]       bo_cnt;

    // First requester at or after rr_ptr (modulo NB_REQ). Scanning from the
    // farthest offset down lets the nearest one overwrite the result last.
    always_comb begin
        pick = '0;
        for (int i = NB_REQ - 1; i >= 0; i--) begin
            if (bus.cons_req[rr_ptr + IDX_W'(i)]) begin
                pick = rr_ptr + IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            rr_ptr          <= '0;
            grant           <= '0;
            bo_cnt          <= '0;
            bus.buf_req     <= 1'b0;
            bus.cons_ack    <= '0;
            bus.cons_hit    <= 1'b0;
            bus.cons_vector <= 8'h00;
            bus.hit_count   <= 8'h00;
            bus.miss_count  <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    if (|bus.cons_req) begin
                        grant       <= pick;
                        bus.buf_req <= 1'b1;
                        state       <= ISSUE;
                    end
                end

                ISSUE: begin
                    bus.buf_req <= 1'b0;
                    state       <= WAIT;
                end

                // Buffer response is on the bus this cycle; the ack, counters
                // and pointer all become visible together in RESP.
                WAIT: begin
                    bus.cons_ack    <= ONE_HOT0 << grant;
                    bus.cons_hit    <= bus.buf_valid;
                    bus.cons_vector <= bus.buf_valid ? bus.buf_vector : 8'h00;
                    if (bus.buf_valid) begin
                        if (bus.hit_count != 8'hFF) begin
                            bus.hit_count <= bus.hit_count + 8'd1;
                        end
                    end else begin
                        if (bus.miss_count != 8'hFF) begin
                            bus.miss_count <= bus.miss_count + 8'd1;
                        end
                    end
                    rr_ptr <= grant + 1'b1;
                    state  <= RESP;
                end

                // cons_hit still holds the captured buf_valid here.
                RESP: begin
                    bus.cons_ack    <= '0;
                    bus.cons_hit    <= 1'b0;
                    bus.cons_vector <= 8'h00;
                    if (!bus.cons_hit && (BACKOFF != 0)) begin
                        bo_cnt <= 4'd0;
                        state  <= HOLD;
                    end else begin
                        state  <= IDLE;
                    end
                end

                HOLD: begin
                    if (bo_cnt == BO_LAST) begin
                        state <= IDLE;
                    end else begin
                        bo_cnt <= bo_cnt + 4'd1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_vector_req_arbiter.sv
module tb_vector_req_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    vector_req_arbiter_if #(.NB_REQ(4)) bus ();

    vector_req_arbiter #(.NB_REQ(4), .BACKOFF(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int         checks   = 0;
    int         failures = 0;
    logic       resp_valid  = 1'b1;
    logic [7:0] resp_vector = 8'hA5;

    // Shared buffer: registered response one cycle after buf_req.
    always @(posedge clk) begin
        if (bus.buf_req) begin
            bus.buf_valid  <= resp_valid;
            bus.buf_vector <= resp_vector;
        end else begin
            bus.buf_valid  <= 1'b0;
            bus.buf_vector <= 8'h00;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.cons_req = 4'b0000;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        bus.cons_req = 4'b0000;
        #2 rst = 1'b1;
        #1;
        checks++; if (bus.buf_req !== 1'b0) begin failures++; $display("FAIL reset_buf_req got=%b exp=0", bus.buf_req); end
        checks++; if (bus.cons_ack !== 4'b0000) begin failures++; $display("FAIL reset_cons_ack got=%b exp=0000", bus.cons_ack); end
        checks++; if (bus.cons_hit !== 1'b0 || bus.cons_vector !== 8'h00) begin failures++; $display("FAIL reset_hit_vec got=%b/%h exp=0/00", bus.cons_hit, bus.cons_vector); end
        checks++; if (bus.hit_count !== 8'h00 || bus.miss_count !== 8'h00) begin failures++; $display("FAIL reset_counts got=%h/%h exp=00/00", bus.hit_count, bus.miss_count); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single_hit();
        resp_valid = 1'b1; resp_vector = 8'hA5;
        bus.cons_req = 4'b0100;
        @(negedge clk);
        checks++; if (bus.buf_req !== 1'b1) begin failures++; $display("FAIL hit_buf_req_c1 got=%b exp=1", bus.buf_req); end
        @(negedge clk);
        checks++; if (bus.buf_req !== 1'b0 || bus.cons_ack !== 4'b0000) begin failures++; $display("FAIL hit_c2 got=%b/%b exp=0/0000", bus.buf_req, bus.cons_ack); end
        @(negedge clk);
        checks++; if (bus.cons_ack !== 4'b0100) begin failures++; $display("FAIL hit_ack got=%b exp=0100", bus.cons_ack); end
        checks++; if (bus.cons_hit !== 1'b1 || bus.cons_vector !== 8'hA5) begin failures++; $display("FAIL hit_data got=%b/%h exp=1/a5", bus.cons_hit, bus.cons_vector); end
        checks++; if (bus.hit_count !== 8'd1) begin failures++; $display("FAIL hit_count got=%0d exp=1", bus.hit_count); end
        bus.cons_req = 4'b0000;
        @(negedge clk);
        checks++; if (bus.cons_ack !== 4'b0000) begin failures++; $display("FAIL hit_ack_one_cycle got=%b exp=0000", bus.cons_ack); end
    endtask

    task automatic test_withdrawn();
        int n_req;
        int n_ack;
        bus.cons_req = 4'b0010;
        @(negedge clk);
        checks++; if (bus.buf_req !== 1'b1) begin failures++; $display("FAIL wd_buf_req got=%b exp=1", bus.buf_req); end
        bus.cons_req = 4'b0000;
        @(negedge clk);
        @(negedge clk);
        checks++; if (bus.cons_ack !== 4'b0010) begin failures++; $display("FAIL wd_ack got=%b exp=0010", bus.cons_ack); end
        checks++; if (bus.hit_count !== 8'd2) begin failures++; $display("FAIL wd_hit_count got=%0d exp=2", bus.hit_count); end
        n_req = 0; n_ack = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (bus.buf_req) n_req++;
            if (bus.cons_ack != 4'b0000) n_ack++;
        end
        checks++; if (n_req != 0 || n_ack != 0) begin failures++; $display("FAIL wd_no_repeat got req=%0d ack=%0d exp=0/0", n_req, n_ack); end
    endtask

    task automatic test_miss_backoff();
        resp_valid = 1'b0;
        do_reset();
        bus.cons_req = 4'b0001;
        repeat (3) @(negedge clk);
        checks++; if (bus.cons_ack !== 4'b0001) begin failures++; $display("FAIL miss_ack got=%b exp=0001", bus.cons_ack); end
        checks++; if (bus.cons_hit !== 1'b0 || bus.cons_vector !== 8'h00) begin failures++; $display("FAIL miss_data got=%b/%h exp=0/00", bus.cons_hit, bus.cons_vector); end
        checks++; if (bus.miss_count !== 8'd1 || bus.hit_count !== 8'd0) begin failures++; $display("FAIL miss_counts got=%0d/%0d exp=1/0", bus.miss_count, bus.hit_count); end
        // Request stays up: next buf_req exactly 5 cycles after the miss ack.
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k == 5) resp_valid = 1'b1;
            checks++; if (bus.buf_req !== (k == 5)) begin failures++; $display("FAIL miss_backoff_k%0d got=%b exp=%b", k, bus.buf_req, (k == 5)); end
        end
        repeat (2) @(negedge clk);
        checks++; if (bus.cons_ack !== 4'b0001 || bus.cons_hit !== 1'b1) begin failures++; $display("FAIL miss_retry got=%b/%b exp=0001/1", bus.cons_ack, bus.cons_hit); end
        bus.cons_req = 4'b0000;
    endtask

    task automatic test_round_robin();
        int last_cyc;
        int cyc;
        bit found;
        logic [3:0] exp_ack;
        do_reset();
        resp_valid = 1'b1; resp_vector = 8'h3C;
        bus.cons_req = 4'b1111;
        cyc = 0; last_cyc = 0;
        for (int k = 0; k < 5; k++) begin
            found = 1'b0;
            for (int c = 0; c < 12 && !found; c++) begin
                @(negedge clk);
                cyc++;
                if (bus.cons_ack != 4'b0000) found = 1'b1;
            end
            exp_ack = 4'b0001 << (k % 4);
            checks++; if (!found) begin failures++; $display("FAIL rr_timeout_%0d got=none exp=%b", k, exp_ack); end
            checks++; if (bus.cons_ack !== exp_ack || bus.cons_vector !== 8'h3C) begin failures++; $display("FAIL rr_order_%0d got=%b/%h exp=%b/3c", k, bus.cons_ack, bus.cons_vector, exp_ack); end
            if (k > 0) begin
                checks++; if (cyc - last_cyc != 4) begin failures++; $display("FAIL rr_spacing_%0d got=%0d exp=4", k, cyc - last_cyc); end
            end
            last_cyc = cyc;
        end
        bus.cons_req = 4'b0000;
    endtask

    task automatic test_mid_reset();
        @(negedge clk);
        resp_vector = 8'h5A;
        bus.cons_req = 4'b1000;
        @(negedge clk);
        checks++; if (bus.buf_req !== 1'b1) begin failures++; $display("FAIL mr_issue got=%b exp=1", bus.buf_req); end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (bus.buf_req !== 1'b0 || bus.cons_ack !== 4'b0000 || bus.cons_hit !== 1'b0 || bus.cons_vector !== 8'h00) begin failures++; $display("FAIL mr_outputs got=%b/%b/%b/%h exp=0/0000/0/00", bus.buf_req, bus.cons_ack, bus.cons_hit, bus.cons_vector); end
        checks++; if (bus.hit_count !== 8'h00 || bus.miss_count !== 8'h00) begin failures++; $display("FAIL mr_counts got=%h/%h exp=00/00", bus.hit_count, bus.miss_count); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (bus.buf_req !== 1'b1 || bus.cons_ack !== 4'b0000) begin failures++; $display("FAIL mr_fresh_issue got=%b/%b exp=1/0000", bus.buf_req, bus.cons_ack); end
        @(negedge clk);
        checks++; if (bus.cons_ack !== 4'b0000) begin failures++; $display("FAIL mr_no_stale_ack got=%b exp=0000", bus.cons_ack); end
        @(negedge clk);
        checks++; if (bus.cons_ack !== 4'b1000 || bus.cons_vector !== 8'h5A || bus.hit_count !== 8'd1) begin failures++; $display("FAIL mr_grant3 got=%b/%h/%0d exp=1000/5a/1", bus.cons_ack, bus.cons_vector, bus.hit_count); end
        bus.cons_req = 4'b0000;
    endtask

    task automatic test_back_to_back();
        do_reset();
        resp_vector = 8'h11;
        bus.cons_req = 4'b1010;
        repeat (3) @(negedge clk);
        checks++; if (bus.cons_ack !== 4'b0010) begin failures++; $display("FAIL b2b_first got=%b exp=0010", bus.cons_ack); end
        repeat (4) @(negedge clk);
        checks++; if (bus.cons_ack !== 4'b1000) begin failures++; $display("FAIL b2b_second got=%b exp=1000", bus.cons_ack); end
        bus.cons_req = 4'b0000;
    endtask

    task automatic test_saturation();
        int acks;
        do_reset();
        resp_valid = 1'b1;
        bus.cons_req = 4'b1111;
        acks = 0;
        for (int c = 0; c < 260 * 4 + 16 && acks < 260; c++) begin
            @(negedge clk);
            if (bus.cons_ack != 4'b0000) begin
                acks++;
                if (acks == 254) begin
                    checks++; if (bus.hit_count !== 8'hFE) begin failures++; $display("FAIL sat_254 got=%h exp=fe", bus.hit_count); end
                end
            end
        end
        bus.cons_req = 4'b0000;
        checks++; if (acks != 260) begin failures++; $display("FAIL sat_acks got=%0d exp=260", acks); end
        checks++; if (bus.hit_count !== 8'hFF || bus.miss_count !== 8'h00) begin failures++; $display("FAIL sat_counts got=%h/%h exp=ff/00", bus.hit_count, bus.miss_count); end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        bus.cons_req = 4'b0000;
        test_reset();
        test_single_hit();
        test_withdrawn();
        test_miss_backoff();
        test_round_robin();
        test_mid_reset();
        test_back_to_back();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
